// File: rtl/mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the memory responder slice:
//   memState_t   responder FSM state encoding (IDLE, BUSY, DONE, RELEASE)
//   LEN_BYTE     MemLength encoding for a byte access
//   LEN_WORD     MemLength encoding for a 32-bit word access
//   CNT_W        width of the wait-state counter
//   formatRead   selects the returned read data from a 32-bit storage word
// Optional feature macro used by this slice: MEM_RESP_ERR_EN
// ---------------------------------------------------------------------------
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } memState_t;

    localparam logic LEN_BYTE = 1'b0;
    localparam logic LEN_WORD = 1'b1;

    localparam int CNT_W = 4;

    // Word accesses return the whole (aligned) word; byte accesses return the
    // addressed lane zero-extended. Lane 0 sits on bits [7:0] (little-endian).
    function automatic logic [31:0] formatRead(input logic        len,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
        logic [31:0] result;
        if (len == LEN_WORD) begin
            result = word;
        end else begin
            result = {24'h000000, word[{lane, 3'b000} +: 8]};
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// ---------------------------------------------------------------------------
// mem_byte_ram
// Four byte-lane storage arrays sharing one word address. Writes are
// synchronous with an independent enable per lane; reads are registered
// (data appears the cycle after rdEn). Contents are never reset.
//
// Ports:
//   Clk     in   clock, all activity on the rising edge
//   wrEn    in   [3:0] per-lane write enable (bit n writes lane n)
//   wrAddr  in   [WORD_BITS-1:0] word address for writes
//   wrData  in   [31:0] write data, lane n on bits [8n+7:8n]
//   rdEn    in   load the read register from rdAddr
//   rdAddr  in   [WORD_BITS-1:0] word address for reads
//   rdData  out  [31:0] registered read data
// Optional feature macro: none (MEM_RESP_ERR_EN does not affect this file)
// ---------------------------------------------------------------------------
module mem_byte_ram #(
    parameter int WORD_BITS = 8
) (
    input  logic                 Clk,
    input  logic [3:0]           wrEn,
    input  logic [WORD_BITS-1:0] wrAddr,
    input  logic [31:0]          wrData,
    input  logic                 rdEn,
    input  logic [WORD_BITS-1:0] rdAddr,
    output logic [31:0]          rdData
);

    localparam int DEPTH = 1 << WORD_BITS;

    for (genvar g = 0; g < 4; g++) begin : gLane
        logic [7:0] laneMem [DEPTH];
        logic [7:0] rdLane;

        always_ff @(posedge Clk) begin
            if (wrEn[g]) begin
                laneMem[wrAddr] <= wrData[8*g +: 8];
            end
            if (rdEn) begin
                rdLane <= laneMem[rdAddr];
            end
        end

        assign rdData[8*g +: 8] = rdLane;
    end

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Simple wait-state memory slave for a processor bus. A request is accepted
// in IDLE, held in BUSY for WAIT_CYCLES extra edges, completed with a single
// MemRdy pulse (DONE), then the responder waits in RELEASE until the
// processor drops MemEnable before it will accept another request.
//
// Handshake: MemEnable is the request-valid and must stay high until MemRdy
// has been seen; MemRdy is a one-cycle completion strobe (no backpressure).
// Dropping MemEnable before MemRdy aborts the access with no side effects;
// keeping it high after MemRdy never starts a second access.
//
// Parameters:
//   ADDR_BITS    byte-address bits decoded (storage is 2^ADDR_BITS bytes)
//   WAIT_CYCLES  wait states before MemRdy, 0..15
// Ports:
//   Clk          in   clock
//   Reset        in   asynchronous active-low reset
//   MemAddr      in   [23:0] byte address (bits above ADDR_BITS ignored)
//   toMemData    in   [31:0] write data
//   MemLength    in   0 = byte, 1 = word
//   MemRd        in   read request
//   MemWr        in   write request
//   MemEnable    in   request valid
//   fromMemData  out  [31:0] read data, updated only when a read completes
//   MemRdy       out  completion pulse
//   MemErr       out  error flag alongside MemRdy (only with MEM_RESP_ERR_EN)
//   dbgState     out  current FSM state
// Optional feature macro: MEM_RESP_ERR_EN (adds MemErr and error handling)
// ---------------------------------------------------------------------------
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [23:0] MemAddr,
    input  logic [31:0] toMemData,
    input  logic        MemLength,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        MemEnable,
    output logic [31:0] fromMemData,
    output logic        MemRdy,
`ifdef MEM_RESP_ERR_EN
    output logic        MemErr,
`endif
    output memState_t   dbgState
);

    localparam int WORD_BITS = ADDR_BITS - 2;

    memState_t             state;
    logic [CNT_W-1:0]      waitCnt;
    logic [ADDR_BITS-1:0]  addrLat;
    logic [31:0]           dataLat;
    logic                  lenLat;
    logic                  readLat;
    logic                  writeLat;
    logic                  errLat;

    logic                  accept;
    logic                  access;
    logic                  reqErr;
    logic [3:0]            ramWrEn;
    logic [31:0]           ramWrData;
    logic [31:0]           ramRdData;

    // Address bits above the decoded range alias onto the same storage.
    if (ADDR_BITS < 24) begin : gUnusedAddr
        logic unusedAddr;
        assign unusedAddr = ^MemAddr[23:ADDR_BITS];
    end

    assign accept   = (state == IDLE) && MemEnable && (MemRd || MemWr);
    assign access   = (state == BUSY) && MemEnable && (waitCnt == '0);
    assign dbgState = state;

`ifdef MEM_RESP_ERR_EN
    assign reqErr = ((MemLength == LEN_WORD) && (MemAddr[1:0] != 2'b00))
                  || (MemRd && MemWr);
`else
    assign reqErr = 1'b0;
`endif

    // Write strobes are raised only on the completing edge, so an aborted or
    // reset access never reaches storage.
    always_comb begin
        ramWrEn   = 4'b0000;
        ramWrData = dataLat;
        if (access && writeLat && !errLat) begin
            if (lenLat == LEN_WORD) begin
                ramWrEn = 4'b1111;
            end else begin
                ramWrEn   = 4'b0001 << addrLat[1:0];
                ramWrData = {4{dataLat[7:0]}};
            end
        end
    end

    // The storage word is fetched on the accepting edge straight from
    // MemAddr, so it is already sitting in the RAM read register by the
    // completing edge, even with zero wait states. Word accesses use the
    // word index only, which forces alignment.
    mem_byte_ram #(
        .WORD_BITS (WORD_BITS)
    ) uRam (
        .Clk    (Clk),
        .wrEn   (ramWrEn),
        .wrAddr (addrLat[ADDR_BITS-1:2]),
        .wrData (ramWrData),
        .rdEn   (accept),
        .rdAddr (MemAddr[ADDR_BITS-1:2]),
        .rdData (ramRdData)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            waitCnt     <= '0;
            addrLat     <= '0;
            dataLat     <= '0;
            lenLat      <= LEN_BYTE;
            readLat     <= 1'b0;
            writeLat    <= 1'b0;
            errLat      <= 1'b0;
            MemRdy      <= 1'b0;
            fromMemData <= '0;
`ifdef MEM_RESP_ERR_EN
            MemErr      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    MemRdy <= 1'b0;
                    if (accept) begin
                        addrLat  <= MemAddr[ADDR_BITS-1:0];
                        dataLat  <= toMemData;
                        lenLat   <= MemLength;
                        // Read wins when both strobes are high.
                        readLat  <= MemRd;
                        writeLat <= MemWr && !MemRd;
                        errLat   <= reqErr;
                        waitCnt  <= CNT_W'(WAIT_CYCLES);
                        state    <= BUSY;
                    end
                end

                BUSY: begin
                    if (!MemEnable) begin
                        waitCnt <= '0;
                        state   <= IDLE;
                    end else if (waitCnt == '0) begin
                        MemRdy <= 1'b1;
`ifdef MEM_RESP_ERR_EN
                        MemErr <= errLat;
`endif
                        if (readLat) begin
                            fromMemData <= errLat ? 32'h0
                                         : formatRead(lenLat, addrLat[1:0], ramRdData);
                        end
                        state <= DONE;
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end

                DONE: begin
                    MemRdy <= 1'b0;
`ifdef MEM_RESP_ERR_EN
                    MemErr <= 1'b0;
`endif
                    state  <= RELEASE;
                end

                RELEASE: begin
                    if (!MemEnable) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    MemRdy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder (ADDR_BITS=10, WAIT_CYCLES=2). Requests
// push their expected read data, error flag and MemRdy cycle into expQ; an
// independent monitor pops and compares on every MemRdy pulse.
// Optional feature macro: MEM_RESP_ERR_EN (enables the error-path vectors)
// ---------------------------------------------------------------------------
module tb_mem_responder;
    import mem_resp_pkg::*;

    localparam int ADDR_BITS = 10;
    localparam int WAIT      = 2;

    // Clock / reset
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [23:0] MemAddr = '0;
    logic [31:0] toMemData = '0;
    logic        MemLength = 1'b0;
    logic        MemRd = 1'b0;
    logic        MemWr = 1'b0;
    logic        MemEnable = 1'b0;
    logic [31:0] fromMemData;
    logic        MemRdy;
`ifdef MEM_RESP_ERR_EN
    logic        MemErr;
`endif
    memState_t   dbgState;

    always #5 Clk = ~Clk;

    int cycle = 0;
    always @(posedge Clk) cycle <= cycle + 1;

    mem_responder #(
        .ADDR_BITS   (ADDR_BITS),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .MemAddr     (MemAddr),
        .toMemData   (toMemData),
        .MemLength   (MemLength),
        .MemRd       (MemRd),
        .MemWr       (MemWr),
        .MemEnable   (MemEnable),
        .fromMemData (fromMemData),
        .MemRdy      (MemRdy),
`ifdef MEM_RESP_ERR_EN
        .MemErr      (MemErr),
`endif
        .dbgState    (dbgState)
    );

    // Scoreboard: {expected MemRdy cycle[15:0], expected MemErr, expected data}
    logic [48:0] expQ[$];
    int checks = 0;
    int passes = 0;
    int rdyCount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge Clk) begin
        if (Reset && MemRdy === 1'b1) begin
            logic [48:0] e;
            rdyCount++;
            if (expQ.size() == 0) begin
                checks++;
                $display("FAIL unexpected_rdy: got MemRdy at cycle %0d, expected none", cycle);
            end else begin
                e = expQ.pop_front();
                chk("rd_data", fromMemData, e[31:0]);
                chk("rdy_latency_cycle", 32'(cycle[15:0]), 32'(e[48:33]));
`ifdef MEM_RESP_ERR_EN
                chk("mem_err", 32'(MemErr), 32'(e[32]));
`endif
            end
        end
    end

    // Driver: issue one request, wait for MemRdy, hold MemEnable for 'hold'
    // extra cycles, then release and let the responder return to IDLE.
    task automatic doReq(input logic rd, input logic wr, input logic len,
                         input logic [23:0] addr, input logic [31:0] wdata,
                         input logic [31:0] expData, input logic expErr,
                         input int hold);
        logic seen;
        @(negedge Clk);
        MemAddr   = addr;
        toMemData = wdata;
        MemLength = len;
        MemRd     = rd;
        MemWr     = wr;
        MemEnable = 1'b1;
        // Accept on the next edge (cycle+1); MemRdy follows edge accept+WAIT+1.
        expQ.push_back({16'(cycle + WAIT + 2), expErr, expData});
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clk);
            seen = (MemRdy === 1'b1);
        end
        if (!seen) begin
            checks++;
            $display("FAIL req_timeout: got no MemRdy for addr 0x%06h, expected one", addr);
            expQ.delete();
        end
        repeat (hold) @(negedge Clk);
        MemEnable = 1'b0;
        MemRd     = 1'b0;
        MemWr     = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
    endtask

    initial begin
        int base;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("reset_rdy", 32'(MemRdy), 32'd0);
        chk("reset_data", fromMemData, 32'h0);
        chk("reset_state", 32'(dbgState), 32'(IDLE));
        Reset = 1'b1;

        // Word write/read, byte lane update, aliasing
        doReq(1'b0, 1'b1, LEN_WORD, 24'h000010, 32'hDEADBEEF, 32'h00000000, 1'b0, 0);
        doReq(1'b1, 1'b0, LEN_WORD, 24'h000010, 32'h0,        32'hDEADBEEF, 1'b0, 0);
        doReq(1'b0, 1'b1, LEN_BYTE, 24'h000013, 32'h0000005A, 32'hDEADBEEF, 1'b0, 0);
        doReq(1'b1, 1'b0, LEN_BYTE, 24'h000013, 32'h0,        32'h0000005A, 1'b0, 0);
        doReq(1'b1, 1'b0, LEN_WORD, 24'h000010, 32'h0,        32'h5AADBEEF, 1'b0, 0);
        doReq(1'b0, 1'b1, LEN_WORD, 24'h000404, 32'h12345678, 32'h5AADBEEF, 1'b0, 0);
        doReq(1'b1, 1'b0, LEN_WORD, 24'h000004, 32'h0,        32'h12345678, 1'b0, 0);
        doReq(1'b1, 1'b0, LEN_BYTE, 24'h000811, 32'h0,        32'h000000BE, 1'b0, 0);

`ifndef MEM_RESP_ERR_EN
        // Misaligned word read is forced aligned; Rd+Wr acts as a read only.
        doReq(1'b1, 1'b0, LEN_WORD, 24'h000012, 32'h0,        32'h5AADBEEF, 1'b0, 0);
        doReq(1'b1, 1'b1, LEN_WORD, 24'h000010, 32'h00000000, 32'h5AADBEEF, 1'b0, 0);
        doReq(1'b1, 1'b0, LEN_WORD, 24'h000010, 32'h0,        32'h5AADBEEF, 1'b0, 0);
`endif

        // Abort: MemEnable dropped during BUSY
        base = rdyCount;
        @(negedge Clk);
        MemAddr = 24'h000010; toMemData = 32'hCAFEF00D; MemLength = LEN_WORD;
        MemRd = 1'b0; MemWr = 1'b1; MemEnable = 1'b1;
        @(negedge Clk);
        MemEnable = 1'b0; MemWr = 1'b0;
        repeat (8) @(negedge Clk);
        chk("abort_no_rdy", 32'(rdyCount), 32'(base));
        doReq(1'b1, 1'b0, LEN_WORD, 24'h000010, 32'h0, 32'h5AADBEEF, 1'b0, 0);

        // Reset asserted mid-BUSY on a pending write
        @(negedge Clk);
        MemAddr = 24'h000010; toMemData = 32'h11111111; MemLength = LEN_WORD;
        MemRd = 1'b0; MemWr = 1'b1; MemEnable = 1'b1;
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        chk("midbusy_reset_rdy", 32'(MemRdy), 32'd0);
        chk("midbusy_reset_data", fromMemData, 32'h0);
        chk("midbusy_reset_state", 32'(dbgState), 32'(IDLE));
        @(negedge Clk);
        MemEnable = 1'b0; MemWr = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        doReq(1'b1, 1'b0, LEN_WORD, 24'h000010, 32'h0, 32'h5AADBEEF, 1'b0, 0);

        // MemEnable held after MemRdy: exactly one pulse
        base = rdyCount;
        doReq(1'b1, 1'b0, LEN_WORD, 24'h000004, 32'h0, 32'h12345678, 1'b0, 4);
        chk("held_enable_one_rdy", 32'(rdyCount), 32'(base + 1));
        doReq(1'b1, 1'b0, LEN_BYTE, 24'h000012, 32'h0, 32'h000000AD, 1'b0, 0);

`ifdef MEM_RESP_ERR_EN
        // Error path: no write on error, reads return 0
        doReq(1'b1, 1'b0, LEN_WORD, 24'h000010, 32'h0,        32'h5AADBEEF, 1'b0, 0);
        doReq(1'b0, 1'b1, LEN_WORD, 24'h000012, 32'hCAFEF00D, 32'h5AADBEEF, 1'b1, 0);
        doReq(1'b1, 1'b0, LEN_WORD, 24'h000011, 32'h0,        32'h00000000, 1'b1, 0);
        doReq(1'b1, 1'b1, LEN_WORD, 24'h000010, 32'hFFFFFFFF, 32'h00000000, 1'b1, 0);
        doReq(1'b1, 1'b0, LEN_WORD, 24'h000010, 32'h0,        32'h5AADBEEF, 1'b0, 0);
`endif

        repeat (5) @(negedge Clk);
        chk("queue_drained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, expected finish");
        $fatal(1);
    end

endmodule
